alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared ALU (ALUControl + alu pair). It accepts operation requests over valid/ready handshakes, grants the ALU round-robin, and drives the ALU's A, B, FuncCode and Opcode inputs from registered operands for one cycle. It captures ALUOut and Branch_Enable and returns them on a single tagged response channel. It sits between the core datapath (requester 0) and an auxiliary unit (requester 1), e.g. an address generator, that shares the one ALU instance.

## Interface
Parameters:
- WIDTH, 32, operand/result width (must match alu).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_func / req1_func  in  4  FuncCode ({instr[30], instr[14:12]}).
- req0_opcode / req1_opcode  in  7  Opcode (instr[6:0]).
- alu_a, alu_b  out  WIDTH  to alu A/B.
- alu_func  out  4  to ALUControl FuncCode.
- alu_opcode  out  7  to ALUControl Opcode.
- alu_out  in  WIDTH  from alu ALUOut (combinational).
- alu_branch  in  1  from alu Branch_Enable (combinational).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  WIDTH  captured ALUOut.
- rsp_branch  out  1  captured Branch_Enable.
- busy  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant0 = req0_valid & (~req1_valid | last_grant==1); grant1 = req1_valid & ~grant0. reqN_ready = (state==IDLE) & grantN (combinational; may depend on valid). On a handshake, latch a, b, func, opcode and id into holding registers, set last_grant = id, and go to EXEC.
- EXEC: alu_a/alu_b/alu_func/alu_opcode are driven from the holding registers (these are registers, so they are stable for the whole cycle). At the end of the cycle, capture alu_out → rsp_result and alu_branch → rsp_branch, then go to RESP.
- RESP: rsp_valid=1. rsp_id/rsp_result/rsp_branch are held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE. No request is accepted in RESP.
- alu_* outputs hold the last latched request outside EXEC. They are not forced to zero.
- Tie with both valid: grant goes to the requester that did not win last. last_grant resets to 1, so requester 0 wins the first tie.
- A requester holding valid without a grant keeps its operands stable. The arbiter does not require this but does not sample them until granted.
- No arithmetic is performed in this block; widths pass through unchanged.

## Timing
- Reset (async, any state) values: state=IDLE, last_grant=1, req0_ready=req1_ready=0 (ready then follows valid combinationally in IDLE), alu_a=alu_b=0, alu_func=0, alu_opcode=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_branch=0, busy=0.
- Reset mid-operation: the in-flight request is dropped and no response is produced.
- Latency: handshake in cycle T → EXEC in T+1 → rsp_valid first high in T+2.
- Back-to-back: with rsp_ready held high, a new request is accepted in T+3, giving a minimum of 3 cycles per operation.
- rsp_ready low stalls in RESP indefinitely with outputs held. Both ready outputs stay 0 throughout.
- A request arriving while busy waits. Fairness bound: a continuously valid requester is granted within 2 operations.

## Test plan
- Reset: assert rst_n=0 mid-EXEC → all outputs at their reset values immediately. After release, rsp_valid stays 0 and the first tie grants port 0.
- Single XOR on port 0: a=0x0000005A, b=0x000000A9, func=4'b0100, opcode=7'b0110011 → rsp_valid at T+2 with rsp_result=0x000000F3, rsp_id=0.
- SLT on port 1 (func=4'b0010, opcode=7'b0110011): a=0xF0000000, b=0x20000000 → rsp_result=1. Then a=0x20000000, b=0xF0000000 → 0. Then a=0xA2345678, b=0x9EA1CD00 → 0.
- Both ports continuously valid for 4 ops → rsp_id sequence 0,1,0,1 with accepts every 3 cycles when rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req*_ready=0. Raise rsp_ready → IDLE next cycle.
- Operand hold: after the accept, change req0_a/b while in EXEC → rsp_result reflects the latched operands only.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU driven from registers) -> RESP (tagged result held).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_func,
    input  logic [6:0]       req0_opcode,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_func,
    input  logic [6:0]       req1_opcode,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    output logic [6:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_branch,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch,

    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both high at the
    // rising edge. Requesters hold their payload while valid is high and not yet accepted;
    // ready may depend combinationally on valid, valid must never depend on ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic   last_grant;
    logic   hold_id;
    logic   grant0;
    logic   grant1;
    logic   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes first.
                grant0 = req0_valid & (~req1_valid | last_grant);
                grant1 = req1_valid & ~grant0;
                accept = grant0 | grant1;
                if (accept) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Gating with rst_n keeps ready low while reset is held even if valid is high.
    assign req0_ready = rst_n & grant0;
    assign req1_ready = rst_n & grant1;

    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    // The ALU drive registers double as the request holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            alu_opcode <= '0;
            hold_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_a      <= grant1 ? req1_a      : req0_a;
            alu_b      <= grant1 ? req1_b      : req0_b;
            alu_func   <= grant1 ? req1_func   : req0_func;
            alu_opcode <= grant1 ? req1_opcode : req0_opcode;
            hold_id    <= grant1;
            last_grant <= grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_id     <= hold_id;
            rsp_result <= alu_out;
            rsp_branch <= alu_branch;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU attached to the ALU port, scoreboard queue of
// expected tagged responses, and a per-cycle model of arbitration and response timing.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int EW = W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_func, req1_func;
    logic [6:0]   req0_opcode, req1_opcode;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_func;
    logic [6:0]   alu_opcode;
    logic         alu_branch;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_branch, busy;
    logic [W-1:0] rsp_result;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_func(req0_func), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_func(req1_func), .req1_opcode(req1_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Behavioural ALUControl+alu: returns {branch, result}.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] f, input logic [6:0] op);
        logic [W-1:0] r;
        logic         br;
        r  = '0;
        br = 1'b0;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            case (f)
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001: r = a << b[4:0];
                4'b0010: r[0] = ($signed(a) < $signed(b));
                4'b0011: r[0] = (a < b);
                4'b0100: r = a ^ b;
                4'b0101: r = a >> b[4:0];
                4'b1101: r = $signed(a) >>> b[4:0];
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                default: r = a + b;
            endcase
        end else if (op == 7'b1100011) begin
            r = a - b;
            case (f[2:0])
                3'd0:    br = (a == b);
                3'd1:    br = (a != b);
                3'd4:    br = ($signed(a) <  $signed(b));
                3'd5:    br = ($signed(a) >= $signed(b));
                3'd6:    br = (a <  b);
                3'd7:    br = (a >= b);
                default: br = 1'b0;
            endcase
        end else begin
            r = a + b;
        end
        return {br, r};
    endfunction

    logic [W:0] alu_tmp;
    always_comb begin
        alu_tmp    = alu_ref(alu_a, alu_b, alu_func, alu_opcode);
        alu_out    = alu_tmp[W-1:0];
        alu_branch = alu_tmp[W];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Scoreboard and reference model state
    logic [EW-1:0] exp_q[$];
    int            acc_log[$];
    logic          id_log[$];
    logic [W-1:0]  res_log[$];
    int            cyc = 0;
    bit            m_pending = 1'b0;
    int            m_acc_cyc = 0;
    bit            m_last = 1'b1;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [W:0]    t;
        logic          g0, g1, hs_id;
        if (!rst_n) begin
            exp_q.delete();
            m_pending = 1'b0;
            m_last    = 1'b1;
        end else begin
            cyc++;
            g0 = 1'b0;
            g1 = 1'b0;
            if (!m_pending) begin
                g0 = req0_valid & (~req1_valid | m_last);
                g1 = req1_valid & ~g0;
            end
            chk("ready", {req1_ready, req0_ready}, {g1, g0});
            chk("busy", busy, m_pending);
            chk("rsp_valid", rsp_valid, m_pending && (cyc >= m_acc_cyc + 2));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = exp_q[0];
                    chk("rsp_id", rsp_id, e[EW-1]);
                    chk("rsp_branch", rsp_branch, e[W]);
                    chk("rsp_result", rsp_result, e[W-1:0]);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        id_log.push_back(rsp_id);
                        res_log.push_back(rsp_result);
                        m_pending = 1'b0;
                    end
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                hs_id = req1_valid && req1_ready;
                t = hs_id ? alu_ref(req1_a, req1_b, req1_func, req1_opcode)
                          : alu_ref(req0_a, req0_b, req0_func, req0_opcode);
                exp_q.push_back({hs_id, t});
                m_pending = 1'b1;
                m_acc_cyc = cyc;
                m_last    = hs_id;
                acc_log.push_back(cyc);
            end
        end
    end

    // Driver tasks: all called at posedge+1 and return at posedge+1.
    logic [3:0] r_funcs [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    logic [2:0] b_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_op(output logic [W-1:0] a, output logic [W-1:0] b,
                           output logic [3:0] f, output logic [6:0] op);
        int k;
        k = $urandom_range(0, 9);
        if (k < 7) begin
            op = 7'b0110011;
            f  = r_funcs[$urandom_range(0, 9)];
        end else if (k < 9) begin
            op = 7'b1100011;
            f  = {1'b0, b_f3[$urandom_range(0, 5)]};
        end else begin
            op = 7'b0000011;
            f  = 4'($urandom_range(0, 15));
        end
        a = pick_val();
        b = ($urandom_range(0, 3) == 0) ? a : pick_val();
    endtask

    task automatic drive_one(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] f, input logic [6:0] op);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_func = f; req0_opcode = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_func = f; req1_opcode = op; req1_valid = 1'b1;
        end
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if ((p == 0) ? req0_ready : req1_ready) done = 1'b1;
        end
        if (!done) fail_now("handshake_timeout");
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic burst(input int p, input int n, input int gap_max);
        logic [W-1:0] a, b;
        logic [3:0]   f;
        logic [6:0]   op;
        repeat (n) begin
            rand_op(a, b, f, op);
            drive_one(p, a, b, f, op);
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_pending || exp_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) fail_now("wait_idle");
    endtask

    task automatic check_reset_values();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_branch", rsp_branch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
    endtask

    bit           rand_done = 1'b0;
    logic [W:0]   t_exp;
    logic [W-1:0] bp_exp;

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0; req0_opcode = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0; req1_opcode = '0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while an operation is in EXEC
        drive_one(0, 32'h0000_1234, 32'h0000_5678, 4'b0000, 7'b0110011);
        chk("exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Both ports continuously valid: first tie goes to port 0, then alternation
        acc_log.delete();
        id_log.delete();
        fork
            burst(0, 2, 0);
            burst(1, 2, 0);
        join
        wait_idle();
        chk("tie_count", id_log.size(), 4);
        for (int i = 0; i < id_log.size(); i++) chk("tie_id", id_log[i], i % 2);
        for (int i = 0; i + 1 < acc_log.size(); i++) chk("tie_gap", acc_log[i+1] - acc_log[i], 3);

        // Directed XOR and SLT cases
        drive_one(0, 32'h0000_005A, 32'h0000_00A9, 4'b0100, 7'b0110011);
        wait_idle();
        chk("xor_result", res_log[$], 32'h0000_00F3);
        chk("xor_id", id_log[$], 0);
        drive_one(1, 32'hF000_0000, 32'h2000_0000, 4'b0010, 7'b0110011);
        wait_idle();
        chk("slt_neg_pos", res_log[$], 1);
        chk("slt_id", id_log[$], 1);
        drive_one(1, 32'h2000_0000, 32'hF000_0000, 4'b0010, 7'b0110011);
        wait_idle();
        chk("slt_pos_neg", res_log[$], 0);
        drive_one(1, 32'hA234_5678, 32'h9EA1_CD00, 4'b0010, 7'b0110011);
        wait_idle();
        chk("slt_both_neg", res_log[$], 0);

        // Backpressure: stall 5 cycles in RESP while port 0 waits
        rsp_ready = 1'b0;
        drive_one(1, 32'h1357_9BDF, 32'h0246_8ACE, 4'b0110, 7'b0110011);
        t_exp  = alu_ref(32'h1357_9BDF, 32'h0246_8ACE, 4'b0110, 7'b0110011);
        bp_exp = t_exp[W-1:0];
        fork
            drive_one(0, 32'h0000_0007, 32'h0000_0003, 4'b1000, 7'b0110011);
            begin
                @(posedge clk);
                #1;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", rsp_valid, 1);
                    chk("bp_result", rsp_result, bp_exp);
                    chk("bp_ready", {req1_ready, req0_ready}, 0);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_sub_result", res_log[$], 4);

        // Operand hold: change port 0 operands while the request is in EXEC
        drive_one(0, 32'h1111_1111, 32'h2222_2222, 4'b0000, 7'b0110011);
        req0_a = $urandom();
        req0_b = $urandom();
        wait_idle();
        chk("hold_result", res_log[$], 32'h3333_3333);

        // Randomised traffic with random response backpressure
        fork
            begin
                fork
                    burst(0, 40, 3);
                    burst(1, 40, 3);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
